// File: rtl/hms_disp_pkg.sv
// Shared constants for the HH.MM.SS multiplexed display: active-low segment
// encodings (seg[0]=a .. seg[6]=g), edit-mode codes and field limits.
package hms_disp_pkg;

  localparam int         NUM_DIGITS = 6;
  localparam logic [5:0] HRS_MAX    = 6'd23;
  localparam logic [5:0] MS_MAX     = 6'd59;

  localparam logic [2:0] MODE_SEC = 3'd1;
  localparam logic [2:0] MODE_MIN = 3'd2;
  localparam logic [2:0] MODE_HRS = 3'd3;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Nibbles above 9 cannot come out of a valid field; show them as a dash.
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    if (v > 4'd9) return SEG_DASH;
    return SEG_DIGIT[v];
  endfunction

endpackage

// File: rtl/hms_display_scan_bin60_to_bcd.sv
// Combinational 6-bit binary (0..63) to two BCD nibbles, plus a flag when the
// value exceeds the caller-supplied field limit.
module bin60_to_bcd (
  input  logic [5:0] bin_i,
  input  logic [5:0] limit_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       oor_o
);

  assign tens_o = 4'(bin_i / 6'd10);
  assign ones_o = 4'(bin_i - 6'(tens_o) * 6'd10);
  assign oor_o  = (bin_i > limit_i);

endmodule

// File: rtl/hms_display_scan.sv
// Scans HH.MM.SS onto digits 5..0 of an 8-digit common-anode display, with a
// per-frame input snapshot and blinking of the field under edit.
module hms_display_scan
  import hms_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [2:0] mode,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic [2:0]    digit_q, digit_d;
  logic          live_q, live_d;
  logic          tick, bterm, frame_start;

  logic [4:0] hrs_q;
  logic [5:0] min_q, sec_q;
  logic [2:0] mode_q;

  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic [3:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
  logic       h_oor, m_oor, s_oor;

  bin60_to_bcd u_hrs (
    .bin_i({1'b0, hrs_q}), .limit_i(HRS_MAX),
    .tens_o(h_tens), .ones_o(h_ones), .oor_o(h_oor)
  );
  bin60_to_bcd u_min (
    .bin_i(min_q), .limit_i(MS_MAX),
    .tens_o(m_tens), .ones_o(m_ones), .oor_o(m_oor)
  );
  bin60_to_bcd u_sec (
    .bin_i(sec_q), .limit_i(MS_MAX),
    .tens_o(s_tens), .ones_o(s_ones), .oor_o(s_oor)
  );

  assign tick  = (presc_q == PW'(REFRESH_DIV - 1));
  assign bterm = (bcnt_q == BW'(BLINK_DIV - 1));

  // live_q marks that the first prescaler tick has happened; until then the
  // display stays dark and the first tick itself opens a frame on digit 0.
  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    bcnt_d      = bterm ? '0 : bcnt_q + 1'b1;
    blink_d     = blink_q ^ bterm;
    digit_d     = digit_q;
    live_d      = live_q;
    frame_start = 1'b0;
    if (tick) begin
      live_d = 1'b1;
      if (!live_q) begin
        frame_start = 1'b1;
      end else if (digit_q == 3'(NUM_DIGITS - 1)) begin
        digit_d     = '0;
        frame_start = 1'b1;
      end else begin
        digit_d = digit_q + 3'd1;
      end
    end
  end

  logic [3:0] nib;
  logic       oor;
  logic [2:0] fmode;

  always_comb begin
    nib   = 4'd0;
    oor   = 1'b0;
    fmode = MODE_SEC;
    case (digit_q)
      3'd0:    begin nib = s_ones; oor = s_oor; fmode = MODE_SEC; end
      3'd1:    begin nib = s_tens; oor = s_oor; fmode = MODE_SEC; end
      3'd2:    begin nib = m_ones; oor = m_oor; fmode = MODE_MIN; end
      3'd3:    begin nib = m_tens; oor = m_oor; fmode = MODE_MIN; end
      3'd4:    begin nib = h_ones; oor = h_oor; fmode = MODE_HRS; end
      3'd5:    begin nib = h_tens; oor = h_oor; fmode = MODE_HRS; end
      default: begin nib = 4'd0;   oor = 1'b1;  fmode = MODE_SEC; end
    endcase
  end

  // Blanking wins over the dash so an out-of-range field still visibly blinks.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (live_q) begin
      an_d[digit_q] = 1'b0;
      seg_d = oor ? SEG_DASH : seg_of(nib);
      dp_d  = !((digit_q == 3'd4) || (digit_q == 3'd2));
      if (blink_q && (mode_q == fmode)) begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      digit_q <= '0;
      live_q  <= 1'b0;
      hrs_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      mode_q  <= '0;
      an_q    <= 8'hFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      digit_q <= digit_d;
      live_q  <= live_d;
      if (frame_start) begin
        hrs_q  <= hrs;
        min_q  <= min;
        sec_q  <= sec;
        mode_q <= mode;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_hms_display_scan.sv
// Directed bench for hms_display_scan with REFRESH_DIV=4, BLINK_DIV=64; every
// cycle's an/seg/dp is checked against hand-entered digit and blink tables.
module tb_hms_display_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] hrs;
  logic [5:0] min, sec;
  logic [2:0] mode;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  int         exp_dig [6];
  logic [5:0] exp_blk;
  logic [6:0] segtab [0:10];

  hms_display_scan #(.REFRESH_DIV(4), .BLINK_DIV(64)) dut (
    .clk(clk), .rst(rst), .hrs(hrs), .min(min), .sec(sec), .mode(mode),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, act, exp);
    end
  endtask

  task automatic set_exp(input int a5, input int a4, input int a3,
                         input int a2, input int a1, input int a0);
    exp_dig[5] = a5; exp_dig[4] = a4; exp_dig[3] = a3;
    exp_dig[2] = a2; exp_dig[1] = a1; exp_dig[0] = a0;
  endtask

  // Outputs after edge c show digit ((c-5)/4)%6 with blink phase ((c-1)/64)%2.
  task automatic scan(input int n);
    for (int i = 0; i < n; i++) begin
      int         c, d;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      c     = cyc;
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (c >= 5) begin
        d       = ((c - 5) / 4) % 6;
        e_an[d] = 1'b0;
        if ((((c - 1) / 64) % 2 == 1) && exp_blk[d]) begin
          e_seg = 7'h7F;
          e_dp  = 1'b1;
        end else begin
          e_seg = segtab[exp_dig[d]];
          e_dp  = !(d == 4 || d == 2);
        end
      end
      chk($sformatf("an@%0d", c), an, e_an);
      chk($sformatf("seg@%0d", c), {1'b0, seg}, {1'b0, e_seg});
      chk($sformatf("dp@%0d", c), {7'd0, dp}, {7'd0, e_dp});
      @(negedge clk);
    end
  endtask

  // Advance (checking) to a given cycle offset within the 24-cycle frame.
  task automatic step_to(input int pos);
    while (!(cyc >= 5 && ((cyc - 5) % 24) == pos)) scan(1);
  endtask

  initial begin
    segtab[0] = 7'h40; segtab[1] = 7'h79; segtab[2] = 7'h24; segtab[3] = 7'h30;
    segtab[4] = 7'h19; segtab[5] = 7'h12; segtab[6] = 7'h02; segtab[7] = 7'h78;
    segtab[8] = 7'h00; segtab[9] = 7'h10; segtab[10] = 7'h3F;

    hrs = 5'd12; min = 6'd34; sec = 6'd56; mode = 3'd0;
    set_exp(1, 2, 3, 4, 5, 6);
    exp_blk = 6'b000000;

    #12;
    @(negedge clk) rst = 1'b0;
    scan(30);

    // reset in the middle of a digit slot: outputs go dark at once
    #2 rst = 1'b1;
    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'd0, dp}, 8'h01);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    scan(53);

    // sec change while digit 3 is lit lands in the following frame
    step_to(13);
    sec = 6'd57;
    scan(11);
    set_exp(1, 2, 3, 4, 5, 7);
    scan(24);

    // out-of-range fields show dashes, dp unaffected
    step_to(12);
    hrs = 5'd25; min = 6'd60; sec = 6'd0;
    scan(12);
    set_exp(10, 10, 10, 10, 0, 0);
    scan(24);

    step_to(12);
    hrs = 5'd24; min = 6'd59; sec = 6'd60;
    scan(12);
    set_exp(10, 10, 5, 9, 10, 10);
    scan(24);

    // editing minutes: digits 3,2 blank during phase 1
    step_to(12);
    hrs = 5'd12; min = 6'd34; sec = 6'd56; mode = 3'd2;
    scan(12);
    set_exp(1, 2, 3, 4, 5, 6);
    exp_blk = 6'b001100;
    scan(160);

    // mode 5 selects no field
    step_to(12);
    mode = 3'd5;
    scan(12);
    exp_blk = 6'b000000;
    scan(140);

    // editing an out-of-range hours field: blank overrides dash
    step_to(12);
    hrs = 5'd25; mode = 3'd3;
    scan(12);
    set_exp(10, 10, 3, 4, 5, 6);
    exp_blk = 6'b110000;
    scan(140);

    // field maxima, then all zeros with leading zeros lit
    step_to(12);
    hrs = 5'd23; min = 6'd59; sec = 6'd59; mode = 3'd0;
    scan(12);
    set_exp(2, 3, 5, 9, 5, 9);
    exp_blk = 6'b000000;
    scan(24);

    step_to(12);
    hrs = 5'd0; min = 6'd0; sec = 6'd0;
    scan(12);
    set_exp(0, 0, 0, 0, 0, 0);
    scan(24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
